m_stage: RTL and testbench

M_STAGE -- requirements
Module: m_stage

---
 rtl/m_stage_if.sv | 31 +++
 rtl/m_stage.sv | 134 +++++++++++++
 tb/tb_m_stage.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/m_stage_if.sv
// Memory-stage bundle: E/M register inputs, forwarding
// inputs and the M/W register outputs.
interface m_stage_if;
  logic [31:0] IRM;
  logic [31:0] PC8M;
  logic [31:0] AOM;
  logic [31:0] RTM;
  logic        Forward_RT_M_Sel;
  logic [31:0] MUX_RF_WD_OUT;
  logic [31:0] IRW;
  logic [31:0] PC8W;
  logic [31:0] AOW;
  logic [31:0] DRW;
  logic [31:0] AO;
  logic [31:0] PC8fromM;
  logic        AdErrW;

  modport master (
    output IRM, PC8M, AOM, RTM,
    output Forward_RT_M_Sel, MUX_RF_WD_OUT,
    input  IRW, PC8W, AOW, DRW,
    input  AO, PC8fromM, AdErrW
  );

  modport slave (
    input  IRM, PC8M, AOM, RTM,
    input  Forward_RT_M_Sel, MUX_RF_WD_OUT,
    output IRW, PC8W, AOW, DRW,
    output AO, PC8fromM, AdErrW
  );
endinterface

// File: rtl/m_stage.sv
// Memory stage: 4 KiB data memory, load extension,
// address-error detection and the M/W pipeline register.
module m_stage (
  input  logic     Clk,
  input  logic     Reset,
  m_stage_if.slave bus
);
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  typedef enum logic [1:0] {
    SZ_NONE, SZ_B, SZ_H, SZ_W
  } size_e;

  logic        is_ld, is_st, sext;
  size_e       sz;
  logic        aderr_d;
  logic [3:0]  be;
  logic [31:0] wd, wdata;
  logic [9:0]  idx;
  logic [31:0] rword, rshift, ext, drw_d;
  logic        we;

  logic [31:0] mem_q [1024];
  logic [31:0] irw_q, pc8w_q, aow_q, drw_q;
  logic        aderr_q;

  // opcode decode: direction, access size, signedness
  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sext  = 1'b0;
    sz    = SZ_NONE;
    unique case (bus.IRM[31:26])
      OP_LW:  begin is_ld = 1'b1; sz = SZ_W; end
      OP_LB:  begin is_ld = 1'b1; sz = SZ_B; sext = 1'b1; end
      OP_LBU: begin is_ld = 1'b1; sz = SZ_B; end
      OP_LH:  begin is_ld = 1'b1; sz = SZ_H; sext = 1'b1; end
      OP_LHU: begin is_ld = 1'b1; sz = SZ_H; end
      OP_SW:  begin is_st = 1'b1; sz = SZ_W; end
      OP_SB:  begin is_st = 1'b1; sz = SZ_B; end
      OP_SH:  begin is_st = 1'b1; sz = SZ_H; end
      default: ;
    endcase
  end

  // address error: out of 4 KiB window or misaligned
  always_comb begin
    aderr_d = 1'b0;
    if (is_ld || is_st)
      aderr_d = (|bus.AOM[31:12])
              | ((sz == SZ_H) & bus.AOM[0])
              | ((sz == SZ_W) & (|bus.AOM[1:0]));
  end

  // byte lanes and lane-replicated store data
  always_comb begin
    be    = 4'b0000;
    wdata = wd;
    case (sz)
      SZ_W: be = 4'b1111;
      SZ_H: begin
        be    = bus.AOM[1] ? 4'b1100 : 4'b0011;
        wdata = {wd[15:0], wd[15:0]};
      end
      SZ_B: begin
        be    = 4'b0001 << bus.AOM[1:0];
        wdata = {4{wd[7:0]}};
      end
      default: ;
    endcase
  end

  assign wd  = bus.Forward_RT_M_Sel ? bus.MUX_RF_WD_OUT
                                    : bus.RTM;
  assign idx = bus.AOM[11:2];
  assign we  = is_st & ~aderr_d;

  // data memory: cleared on reset, byte-lane writes
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < 1024; i++)
        mem_q[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b])
          mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // asynchronous read returns pre-write contents
  always_comb begin
    rword  = mem_q[idx];
    rshift = rword >> {bus.AOM[1:0], 3'b000};
    ext    = rword;
    case (sz)
      SZ_B: ext = {{24{sext & rshift[7]}}, rshift[7:0]};
      SZ_H: ext = {{16{sext & rshift[15]}}, rshift[15:0]};
      default: ;
    endcase
    drw_d = (is_ld && !aderr_d) ? ext : 32'h0;
  end

  // M/W pipeline register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      irw_q   <= '0;
      pc8w_q  <= '0;
      aow_q   <= '0;
      drw_q   <= '0;
      aderr_q <= 1'b0;
    end else begin
      irw_q   <= bus.IRM;
      pc8w_q  <= bus.PC8M;
      aow_q   <= bus.AOM;
      drw_q   <= drw_d;
      aderr_q <= aderr_d;
    end
  end

  assign bus.IRW      = irw_q;
  assign bus.PC8W     = pc8w_q;
  assign bus.AOW      = aow_q;
  assign bus.DRW      = drw_q;
  assign bus.AdErrW   = aderr_q;
  assign bus.AO       = bus.AOM;
  assign bus.PC8fromM = bus.PC8M;
endmodule

// File: tb/tb_m_stage.sv
// Bench for m_stage: directed vector table, reset
// sequence and random traffic against a byte-array model.
module tb_m_stage;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mb [4096];

  m_stage_if bus ();

  m_stage dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] ao;
    logic [31:0] rt;
    logic        fs;
    logic [31:0] fw;
    logic [31:0] drw;
    logic        err;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h",
               nm, act, exp);
    end
  endtask

  // size in bytes (0 = not a memory op), load, signed
  task automatic dec(input logic [5:0] op,
                     output int sz, output bit ld,
                     output bit sg);
    sz = 0; ld = 0; sg = 0;
    case (op)
      OP_LW:  begin sz = 4; ld = 1; end
      OP_LB:  begin sz = 1; ld = 1; sg = 1; end
      OP_LBU: begin sz = 1; ld = 1; end
      OP_LH:  begin sz = 2; ld = 1; sg = 1; end
      OP_LHU: begin sz = 2; ld = 1; end
      OP_SW:  sz = 4;
      OP_SB:  sz = 1;
      OP_SH:  sz = 2;
      default: ;
    endcase
  endtask

  task automatic step(input logic rn,
                      input logic [31:0] ir,
                      input logic [31:0] pc8,
                      input logic [31:0] ao,
                      input logic [31:0] rt,
                      input logic fs,
                      input logic [31:0] fw);
    int sz; bit ld, sg, err;
    int a;
    logic [31:0] v, wd;
    @(negedge Clk);
    Reset = rn;
    bus.IRM = ir;
    bus.PC8M = pc8;
    bus.AOM = ao;
    bus.RTM = rt;
    bus.Forward_RT_M_Sel = fs;
    bus.MUX_RF_WD_OUT = fw;
    dec(ir[31:26], sz, ld, sg);
    err = (sz != 0) &&
          (ao >= 32'd4096 || (ao % sz) != 0);
    a = int'(ao[11:0]);
    v = 32'h0;
    if (ld && !err) begin
      for (int k = 0; k < sz; k++)
        v = v | (32'(mb[a+k]) << (8*k));
      if (sg && sz < 4 && v[8*sz-1])
        v = v | (32'hFFFFFFFF << (8*sz));
    end
    wd = fs ? fw : rt;
    #1;
    chk("AO", bus.AO, ao);
    chk("PC8fromM", bus.PC8fromM, pc8);
    @(posedge Clk);
    if (!rn) begin
      for (int i = 0; i < 4096; i++) mb[i] = 8'h0;
    end else if (!ld && sz != 0 && !err) begin
      for (int k = 0; k < sz; k++)
        mb[a+k] = wd[8*k +: 8];
    end
    #1;
    chk("IRW", bus.IRW, rn ? ir : 32'h0);
    chk("PC8W", bus.PC8W, rn ? pc8 : 32'h0);
    chk("AOW", bus.AOW, rn ? ao : 32'h0);
    chk("DRW", bus.DRW, rn ? v : 32'h0);
    chk("AdErrW", {31'b0, bus.AdErrW},
        {31'b0, rn && err});
  endtask

  function automatic logic [31:0] mkir(
      input logic [5:0] op);
    return {op, 26'h0ABCDE};
  endfunction

  initial begin
    logic [5:0] ops [11];
    logic [31:0] r, ir, ao;
    ops = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU,
            OP_SW, OP_SB, OP_SH,
            6'h00, 6'h08, 6'h0F};
    for (int i = 0; i < 4096; i++) mb[i] = 8'hXX;

    tbl[0]  = '{OP_SW,  32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        32'h0,        1'b0};
    tbl[1]  = '{OP_LW,  32'h10,   32'h0,        1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{OP_SW,  32'h20,   32'h000080FF, 1'b0, 32'h0,        32'h0,        1'b0};
    tbl[3]  = '{OP_LB,  32'h20,   32'h0,        1'b0, 32'h0,        32'hFFFFFFFF, 1'b0};
    tbl[4]  = '{OP_LBU, 32'h21,   32'h0,        1'b0, 32'h0,        32'h00000080, 1'b0};
    tbl[5]  = '{OP_LH,  32'h20,   32'h0,        1'b0, 32'h0,        32'hFFFF80FF, 1'b0};
    tbl[6]  = '{OP_LHU, 32'h22,   32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
    tbl[7]  = '{OP_SW,  32'h30,   32'h11223344, 1'b0, 32'h0,        32'h0,        1'b0};
    tbl[8]  = '{OP_SB,  32'h33,   32'h000000AB, 1'b0, 32'h0,        32'h0,        1'b0};
    tbl[9]  = '{OP_LW,  32'h30,   32'h0,        1'b0, 32'h0,        32'hAB223344, 1'b0};
    tbl[10] = '{OP_SH,  32'h32,   32'h00005566, 1'b0, 32'h0,        32'h0,        1'b0};
    tbl[11] = '{OP_LW,  32'h30,   32'h0,        1'b0, 32'h0,        32'h55663344, 1'b0};
    tbl[12] = '{OP_SW,  32'h40,   32'h0,        1'b1, 32'h12345678, 32'h0,        1'b0};
    tbl[13] = '{OP_LW,  32'h40,   32'h0,        1'b0, 32'h0,        32'h12345678, 1'b0};
    tbl[14] = '{OP_LW,  32'h41,   32'h0,        1'b0, 32'h0,        32'h0,        1'b1};
    tbl[15] = '{OP_SW,  32'h2000, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h0,        1'b1};
    tbl[16] = '{OP_LW,  32'h0,    32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
    tbl[17] = '{6'h00,  32'h10,   32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
    tbl[18] = '{OP_SH,  32'h31,   32'h0000FFFF, 1'b0, 32'h0,        32'h0,        1'b1};
    tbl[19] = '{OP_LW,  32'h30,   32'h0,        1'b0, 32'h0,        32'h55663344, 1'b0};

    // reset with a store presented: store must be dropped
    step(1'b0, mkir(OP_SW), 32'h8, 32'h10,
         32'h77, 1'b0, 32'h0);
    step(1'b0, mkir(OP_SW), 32'hC, 32'h14,
         32'h77, 1'b0, 32'h0);

    for (int i = 0; i < 20; i++) begin
      ir = (tbl[i].op == 6'h00) ? 32'h0
                                : mkir(tbl[i].op);
      step(1'b1, ir, 32'h400000 + 32'(i*4),
           tbl[i].ao, tbl[i].rt, tbl[i].fs, tbl[i].fw);
      chk($sformatf("tbl%0d_drw", i),
          bus.DRW, tbl[i].drw);
      chk($sformatf("tbl%0d_err", i),
          {31'b0, bus.AdErrW}, {31'b0, tbl[i].err});
    end

    // store, reset mid-stream, then memory reads zero
    step(1'b1, mkir(OP_SW), 32'h100, 32'h0,
         32'h1, 1'b0, 32'h0);
    step(1'b1, mkir(OP_LW), 32'h104, 32'h0,
         32'h0, 1'b0, 32'h0);
    chk("pre_rst_lw0", bus.DRW, 32'h1);
    step(1'b0, mkir(OP_SW), 32'h108, 32'h10,
         32'h99, 1'b0, 32'h0);
    chk("rst_irw", bus.IRW, 32'h0);
    chk("rst_drw", bus.DRW, 32'h0);
    step(1'b1, mkir(OP_LW), 32'h10C, 32'h0,
         32'h0, 1'b0, 32'h0);
    chk("rst_lw0", bus.DRW, 32'h0);
    chk("rst_irw_next", bus.IRW, mkir(OP_LW));
    step(1'b1, mkir(OP_LW), 32'h110, 32'h10,
         32'h0, 1'b0, 32'h0);
    chk("rst_lw10", bus.DRW, 32'h0);

    // random traffic over a small window
    for (int n = 0; n < 400; n++) begin
      r  = $urandom();
      ir = {ops[$urandom_range(0, 10)], r[25:0]};
      if ($urandom_range(0, 15) == 0) ir = 32'h0;
      if ($urandom_range(0, 9) == 0)
        ao = $urandom();
      else
        ao = 32'($urandom_range(0, 127));
      step(($urandom_range(0, 39) != 0), ir,
           $urandom(), ao, $urandom(),
           1'($urandom_range(0, 1)), $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
